// File: rtl/pulse_tx_pkg.sv
// pulse_tx_pkg: shared types and default widths for the pulse transmitter
package pulse_tx_pkg;
    localparam int DURATION_BITS_DEF  = 8;
    localparam int FIFO_DEPTH_DEF     = 4;
    localparam int PRESCALER_BITS_DEF = 4;
    typedef enum logic {IDLE, RUN} seq_state_t;
    typedef struct packed {
        logic                         level;
        logic [DURATION_BITS_DEF-1:0] duration;
    } symbol_t;
endpackage

// File: rtl/pulse_symbol_fifo.sv
// pulse_symbol_fifo: circular-pointer symbol FIFO with occupancy count and flush
module pulse_symbol_fifo import pulse_tx_pkg::*; #(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = $bits(symbol_t)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/pulse_symbol_sequencer.sv
// pulse_symbol_sequencer: plays queued level/duration symbols, timed by prescaler toggle ticks
module pulse_symbol_sequencer import pulse_tx_pkg::*; #(
    parameter int DURATION_BITS = DURATION_BITS_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         sys_rst_n,
    input  logic                         enable,
    input  logic                         flush,
    input  logic                         idle_level,
    input  logic                         sym_valid,
    output logic                         sym_ready,
    input  logic                         sym_level,
    input  logic [DURATION_BITS-1:0]     sym_duration,
    input  logic                         tick_toggle,
    output logic                         timer_clear,
    output logic                         pulse_out,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int SW = DURATION_BITS + 1;
    seq_state_t state, state_n;
    logic prev_toggle, entry, entry_n, pulse_n, clear_n, done_n, pop, full, empty, tick;
    logic [DURATION_BITS-1:0] remaining, rem_n;
    logic [SW-1:0] head;
    assign sym_ready = !full;
    // the entry cycle of RUN ignores ticks so a stale toggle from clear release cannot count
    assign tick = (tick_toggle ^ prev_toggle) && !entry;
    pulse_symbol_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SW)) u_fifo (
        .clk(clk), .rst_n(sys_rst_n), .flush(flush), .push(sym_valid), .pop(pop),
        .wdata({sym_level, sym_duration}), .rdata(head), .full(full), .empty(empty),
        .count(fifo_count)
    );
    always_comb begin
        state_n = state;
        pulse_n = pulse_out;
        rem_n   = remaining;
        clear_n = timer_clear;
        done_n  = 1'b0;
        entry_n = 1'b0;
        pop     = 1'b0;
        if (state == IDLE) begin
            clear_n = 1'b1;
            pulse_n = idle_level;
            if (enable && !empty) begin
                pop     = 1'b1;
                state_n = RUN;
                pulse_n = head[SW-1];
                rem_n   = head[DURATION_BITS-1:0];
                clear_n = 1'b0;
                entry_n = 1'b1;
            end
        end else if (tick) begin
            if (remaining != '0) begin
                rem_n = remaining - 1'b1;
            end else if (enable && !empty) begin
                pop     = 1'b1;
                pulse_n = head[SW-1];
                rem_n   = head[DURATION_BITS-1:0];
            end else begin
                state_n = IDLE;
                pulse_n = idle_level;
                clear_n = 1'b1;
                done_n  = 1'b1;
            end
        end
        if (flush) begin
            state_n = IDLE;
            pulse_n = idle_level;
            clear_n = 1'b1;
            done_n  = 1'b0;
            entry_n = 1'b0;
            pop     = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state       <= IDLE;
            prev_toggle <= 1'b0;
            entry       <= 1'b0;
            remaining   <= '0;
            pulse_out   <= 1'b0;
            timer_clear <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            prev_toggle <= tick_toggle;
            entry       <= entry_n;
            remaining   <= rem_n;
            pulse_out   <= pulse_n;
            timer_clear <= clear_n;
            busy        <= state_n == RUN;
            done        <= done_n;
        end
endmodule

// File: tb/tb_pulse_symbol_sequencer.sv
// tb_pulse_symbol_sequencer: directed checks of symbol timing, FIFO flow, flush and reset
module tb_pulse_symbol_sequencer;
    logic clk = 0, sys_rst_n = 0, enable = 0, flush = 0, idle_level = 0;
    logic sym_valid = 0, sym_level = 0, tog = 0;
    logic [7:0] sym_duration = 0;
    logic sym_ready, timer_clear, pulse_out, busy, done;
    logic [2:0] fifo_count;
    int half = 2, pc = 1, passed = 0, total = 0, n;
    logic [15:0] wave;

    pulse_symbol_sequencer dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .enable(enable), .flush(flush),
        .idle_level(idle_level), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_level(sym_level), .sym_duration(sym_duration), .tick_toggle(tog),
        .timer_clear(timer_clear), .pulse_out(pulse_out), .busy(busy), .done(done),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // prescaler stand-in: first toggle is seen exactly half cycles after start
    always @(posedge clk)
        if (timer_clear) begin pc <= 1; tog <= 0; end
        else if (pc >= half - 1) begin pc <= 0; tog <= ~tog; end
        else pc <= pc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic push(input logic lv, input logic [7:0] d);
        sym_valid = 1; sym_level = lv; sym_duration = d;
        @(negedge clk);
        sym_valid = 0;
    endtask

    task automatic run_len(output int len);
        len = 0;
        while (pulse_out === 1'b1 && len < 2000) begin len++; @(negedge clk); end
    endtask

    initial begin
        cyc(2);
        chk("rst_pulse", pulse_out, 0);
        chk("rst_clear", timer_clear, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", fifo_count, 0);
        sys_rst_n = 1;
        cyc(1);
        chk("rst_ready", sym_ready, 1);

        // single symbol {1,2}, half-period 4
        half = 4;
        push(1, 2);
        chk("t1_count", fifo_count, 1);
        enable = 1;
        cyc(1);
        chk("t1_busy", busy, 1);
        chk("t1_clear", timer_clear, 0);
        run_len(n);
        chk("t1_len", n, 12);
        chk("t1_done", done, 1);
        chk("t1_idle", busy, 0);
        chk("t1_clear_end", timer_clear, 1);
        cyc(1);
        chk("t1_done_once", done, 0);

        // four chained symbols, half-period 2, idle high
        enable = 0; half = 2; idle_level = 1;
        cyc(1);
        push(1, 0); push(0, 1); push(1, 3); push(0, 0);
        chk("t2_full", fifo_count, 4);
        chk("t2_ready_low", sym_ready, 0);
        enable = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wave[15-i] = pulse_out;
            if (i == 0) chk("t2_pop_count", fifo_count, 3);
        end
        chk("t2_wave", wave, 16'b1100_0011_1111_1100);
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_idle_level", pulse_out, 1);

        // full FIFO with sym_valid held through a pop, then flush with push
        enable = 0; idle_level = 0;
        cyc(2);
        push(0, 3); push(0, 0); push(0, 0); push(0, 0);
        chk("t3_full", fifo_count, 4);
        chk("t3_ready_full", sym_ready, 0);
        sym_valid = 1; sym_level = 1; sym_duration = 0; enable = 1;
        @(negedge clk);
        chk("t3_count3", fifo_count, 3);
        chk("t3_ready_up", sym_ready, 1);
        @(negedge clk);
        chk("t3_count4", fifo_count, 4);
        chk("t3_ready_down", sym_ready, 0);
        sym_valid = 0; idle_level = 1;
        cyc(1);
        chk("t3_busy", busy, 1);
        chk("t3_level", pulse_out, 0);
        flush = 1; sym_valid = 1;
        @(negedge clk);
        flush = 0; sym_valid = 0;
        chk("t5_busy", busy, 0);
        chk("t5_count", fifo_count, 0);
        chk("t5_pulse", pulse_out, 1);
        chk("t5_clear", timer_clear, 1);
        chk("t5_no_done", done, 0);
        @(negedge clk);
        chk("t5_no_done2", done, 0);
        chk("t5_push_lost", fifo_count, 0);
        idle_level = 0;
        cyc(2);

        // enable dropped during 2nd of three symbols
        enable = 0;
        push(1, 1); push(0, 1); push(1, 0);
        enable = 1;
        cyc(6);
        chk("t4_sym2", pulse_out, 0);
        chk("t4_count", fifo_count, 1);
        enable = 0;
        cyc(2);
        chk("t4_still_busy", busy, 1);
        cyc(1);
        chk("t4_done", done, 1);
        chk("t4_idle", busy, 0);
        cyc(3);
        chk("t4_retained", fifo_count, 1);
        enable = 1;
        cyc(1);
        chk("t4_restart", busy, 1);
        chk("t4_sym3", pulse_out, 1);
        chk("t4_empty", fifo_count, 0);
        cyc(1);
        chk("t4_sym3_hold", busy, 1);
        cyc(1);
        chk("t4_done2", done, 1);

        // maximum duration: 256 ticks
        enable = 0;
        cyc(1);
        push(1, 8'hFF);
        enable = 1;
        cyc(1);
        run_len(n);
        chk("tmax_len", n, 512);
        chk("tmax_done", done, 1);

        // async reset mid-RUN
        enable = 0;
        cyc(1);
        push(1, 5); push(1, 5);
        enable = 1;
        cyc(3);
        chk("tr_busy", busy, 1);
        chk("tr_pulse", pulse_out, 1);
        chk("tr_count", fifo_count, 1);
        @(posedge clk);
        #2 sys_rst_n = 0;
        #1;
        chk("tr_pulse0", pulse_out, 0);
        chk("tr_clear1", timer_clear, 1);
        chk("tr_busy0", busy, 0);
        chk("tr_count0", fifo_count, 0);
        @(negedge clk);
        sys_rst_n = 1;
        @(negedge clk);
        chk("tr_ready", sym_ready, 1);
        chk("tr_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pulse_symbol_sequencer.md
# pulse_symbol_sequencer

Downstream consumer of the prescaler timer in the pulse transmitter. Holds a small FIFO of symbols (output level + duration), detects every toggle of the prescaler's divided output as one tick, and drives `pulse_out` at each symbol's level for (duration+1) ticks. Controls the prescaler's clear input so that tick phase restarts cleanly on every transmission.

## Interface
Parameters:
- `DURATION_BITS`, 8: width of a symbol's duration field.
- `FIFO_DEPTH`, 4: symbol FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  permit transmission start and symbol chaining.
- `flush`  in  1  synchronous abort: empty the FIFO, go idle.
- `idle_level`  in  1  `pulse_out` level while idle.
- `sym_valid`  in  1  symbol offered.
- `sym_ready`  out  1  FIFO can accept; equals !full.
- `sym_level`  in  1  symbol output level.
- `sym_duration`  in  DURATION_BITS  tick count minus one.
- `tick_toggle`  in  1  divided output of the prescaler timer; each change is one tick.
- `timer_clear`  out  1  high holds the prescaler in its cleared state (output 0).
- `pulse_out`  out  1  transmitted waveform.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle strobe when a transmission ends normally.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- Tick detect: register `prev_toggle` every cycle; tick = `tick_toggle` ^ `prev_toggle`.
- FSM states IDLE, RUN.
- IDLE: `timer_clear`=1, `pulse_out`=`idle_level`, `busy`=0. If `enable` and `fifo_count`≠0: pop the head, load `pulse_out`←level and `remaining`←duration, go to RUN.
- RUN: `timer_clear`=0, `busy`=1. Ticks are ignored in IDLE and in the entry cycle of RUN.
  - On tick with `remaining`≠0: decrement `remaining`.
  - On tick with `remaining`=0: if `enable` and FIFO non-empty, pop and load the next symbol in the same cycle, staying in RUN (no tick lost, no gap). Otherwise go to IDLE with `pulse_out`←`idle_level`, `timer_clear`←1, and `done`=1 for one cycle.
- `enable` deasserted mid-RUN: the current symbol completes, then the block goes idle with `done`. The FIFO contents are retained.
- `flush`: highest priority. Next cycle the state is IDLE, `fifo_count`=0, `pulse_out`=`idle_level`, `timer_clear`=1, and no `done`. A push in the same cycle is discarded.
- FIFO push: `sym_valid`&&`sym_ready`&&!`flush`. When full, `sym_ready`=0 even if a pop occurs that cycle. When empty, there is no bypass: a push is poppable from the next cycle. Simultaneous push and pop leaves the count unchanged.
- Duration arithmetic: unsigned. Duration 0 gives 1 tick; the maximum gives 2^DURATION_BITS ticks. `remaining` never wraps.

## Timing
- Reset values: state IDLE, `pulse_out`=0, `timer_clear`=1, `busy`=0, `done`=0, `fifo_count`=0, `sym_ready`=1 once out of reset, `prev_toggle`=0.
- All outputs are registered, except `sym_ready`, which is decoded from the registered count.
- Start latency: the start condition is sampled at edge N. At N, `pulse_out` takes the first level and `timer_clear` falls.
- Symbol change latency: a `tick_toggle` change seen at edge N updates `pulse_out` at edge N.
- Nominal symbol length is (duration+1)·2^prescaler clk cycles, given the prescaler's half-period 2^prescaler.
- `done` asserts in the cycle after the final tick edge.
- Reset mid-RUN: all state returns to reset values immediately.

## Structure
- Shared package `pulse_tx_pkg`:
  - state enum `seq_state_t` {IDLE, RUN}
  - symbol struct `symbol_t` {level, duration}
  - default width localparams shared with the prescaler timer
- Sub-module `pulse_symbol_fifo`: synchronous FIFO with circular pointers, count, and flush; parameterised by DEPTH and by the `symbol_t` width.
- Sequencer FSM, tick detect and `remaining` counter live in the top module.

## Test plan
- Single symbol {1, 2}, prescaler half-period 4, `idle_level`=0: `pulse_out` high for exactly 12 clk, then 0; `done` strobes once; `busy` drops.
- Four symbols {1,0},{0,1},{1,3},{0,0} with half-period 2: high 2, low 4, high 8, low 2 clk, with no gap cycles; `sym_ready` is low while 4 entries are held.
- Fill to `FIFO_DEPTH`, then hold `sym_valid` high during a pop: no overflow. `fifo_count` reads 4 → 3 → 4 and `sym_ready` follows.
- `enable` dropped during the 2nd of three symbols: the 2nd completes, then idle with `done`. `fifo_count`=1 is retained; re-enabling sends the 3rd.
- `flush` asserted mid-RUN together with a push: the next cycle is IDLE with count 0, `pulse_out`=`idle_level`, and no `done`.
- Async reset asserted mid-RUN, between clock edges: outputs take their reset values without waiting for a clk edge.
